// File: rtl/ecc_pkg.sv
// SECDED helpers. Codeword layout: bit 0 holds the overall parity. Bits 1..N are
// Hamming positions, with check bits at the power-of-two positions.
package ecc_pkg;

  function automatic int unsigned get_syn_width(input int unsigned data_width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (r == 0 && (32'd1 << i) >= data_width + i + 1) r = i;
    end
    return r;
  endfunction

  // Hamming width only; the overall-parity bit is added on top by the users
  function automatic int unsigned get_cw_width(input int unsigned data_width);
    return data_width + get_syn_width(data_width);
  endfunction

  // With positional layout the syndrome is the flipped bit index; 0 means bit 0
  function automatic int unsigned syn_to_pos(input int unsigned syn);
    return syn;
  endfunction

endpackage

// File: rtl/ecc_decode.sv
// Combinational SECDED check/correct of one codeword.
module ecc_decode
  import ecc_pkg::*;
#(
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned CwWidth   = get_cw_width(DataWidth) + 1,
  localparam int unsigned SynWidth  = get_syn_width(DataWidth)
) (
  input  logic [CwWidth-1:0] cw_i,
  output logic [CwWidth-1:0] cw_o,
  output logic               single_error_o,
  output logic               double_error_o
);

  logic [SynWidth-1:0] syn;
  logic                parity;
  int unsigned         pos;
  logic                single;

  always_comb begin
    syn = '0;
    for (int unsigned i = 1; i < CwWidth; i++) begin
      if (cw_i[i]) syn = syn ^ SynWidth'(i);
    end
    parity = ^cw_i;
    pos    = syn_to_pos(32'(syn));
    // Odd parity pointing outside the codeword can only come from a multi-bit error
    single         = parity && (pos < CwWidth);
    double_error_o = (!parity && (syn != '0)) || (parity && (pos >= CwWidth));
    single_error_o = single;
    for (int unsigned i = 0; i < CwWidth; i++) begin
      cw_o[i] = cw_i[i] ^ (single && (pos == i));
    end
  end

endmodule

// File: rtl/ecc_scrubber.sv
// Background SECDED scrubber for one SRAM bank; the user port always takes priority.
module ecc_scrubber
  import ecc_pkg::*;
#(
  parameter  int unsigned BankSize  = 256,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned CwWidth   = get_cw_width(DataWidth) + 1,
  localparam int unsigned AddrWidth = $clog2(BankSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scrub_trigger_i,
  input  logic                 bank_req_i,
  input  logic                 bank_we_i,
  input  logic [AddrWidth-1:0] bank_add_i,
  input  logic [CwWidth-1:0]   bank_wdata_i,
  output logic [CwWidth-1:0]   bank_rdata_o,
  output logic                 ecc_req_o,
  output logic                 ecc_we_o,
  output logic [AddrWidth-1:0] ecc_add_o,
  output logic [CwWidth-1:0]   ecc_wdata_o,
  input  logic [CwWidth-1:0]   ecc_rdata_i,
  output logic                 scrub_fix_o,
  output logic                 scrub_uncorrectable_o,
  output logic [31:0]          nb_corrected_o,
  output logic [31:0]          nb_uncorrectable_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e               state;
  logic [AddrWidth-1:0] scrub_addr;
  logic [AddrWidth-1:0] next_addr;
  logic [CwWidth-1:0]   fix_cw;
  logic [CwWidth-1:0]   dec_cw;
  logic                 single_err;
  logic                 double_err;
  logic                 user_hit;

  assign bank_rdata_o = ecc_rdata_i;

  ecc_decode #(
    .DataWidth(DataWidth)
  ) u_decode (
    .cw_i          (ecc_rdata_i),
    .cw_o          (dec_cw),
    .single_error_o(single_err),
    .double_error_o(double_err)
  );

  assign next_addr = (scrub_addr == AddrWidth'(BankSize - 1)) ? '0 : scrub_addr + 1'b1;
  assign user_hit  = bank_req_i && bank_we_i && (bank_add_i == scrub_addr);

  // SRAM port mux is combinational so the user sees no extra latency
  always_comb begin
    ecc_req_o   = 1'b0;
    ecc_we_o    = 1'b0;
    ecc_add_o   = '0;
    ecc_wdata_o = '0;
    if (bank_req_i) begin
      ecc_req_o   = 1'b1;
      ecc_we_o    = bank_we_i;
      ecc_add_o   = bank_add_i;
      ecc_wdata_o = bank_wdata_i;
    end else if (rst_ni) begin
      if (state == IDLE && scrub_trigger_i) begin
        ecc_req_o = 1'b1;
        ecc_add_o = scrub_addr;
      end else if (state == WRITE) begin
        ecc_req_o   = 1'b1;
        ecc_we_o    = 1'b1;
        ecc_add_o   = scrub_addr;
        ecc_wdata_o = fix_cw;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                 <= IDLE;
      scrub_addr            <= '0;
      fix_cw                <= '0;
      scrub_fix_o           <= 1'b0;
      scrub_uncorrectable_o <= 1'b0;
      nb_corrected_o        <= '0;
      nb_uncorrectable_o    <= '0;
    end else begin
      scrub_fix_o           <= 1'b0;
      scrub_uncorrectable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (scrub_trigger_i && !bank_req_i) state <= READ;
        end
        READ: begin
          if (double_err) begin
            scrub_uncorrectable_o <= 1'b1;
            if (nb_uncorrectable_o != '1) nb_uncorrectable_o <= nb_uncorrectable_o + 32'd1;
            scrub_addr <= next_addr;
            state      <= IDLE;
          end else if (single_err) begin
            scrub_fix_o <= 1'b1;
            if (nb_corrected_o != '1) nb_corrected_o <= nb_corrected_o + 32'd1;
            fix_cw <= dec_cw;
            state  <= WRITE;
          end else begin
            scrub_addr <= next_addr;
            state      <= IDLE;
          end
        end
        WRITE: begin
          // A user write to the same word supersedes the stale correction
          if (!bank_req_i || user_hit) begin
            scrub_addr <= next_addr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber with a 1-cycle-latency SRAM model.
module tb_ecc_scrubber;

  localparam int unsigned BankSize  = 8;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned CwWidth   = 39;
  localparam int unsigned AW        = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               scrub_trigger_i;
  logic               bank_req_i, bank_we_i;
  logic [AW-1:0]      bank_add_i;
  logic [CwWidth-1:0] bank_wdata_i, bank_rdata_o;
  logic               ecc_req_o, ecc_we_o;
  logic [AW-1:0]      ecc_add_o;
  logic [CwWidth-1:0] ecc_wdata_o, ecc_rdata_i;
  logic               scrub_fix_o, scrub_uncorrectable_o;
  logic [31:0]        nb_corrected_o, nb_uncorrectable_o;

  ecc_scrubber #(
    .BankSize (BankSize),
    .DataWidth(DataWidth)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .scrub_trigger_i      (scrub_trigger_i),
    .bank_req_i           (bank_req_i),
    .bank_we_i            (bank_we_i),
    .bank_add_i           (bank_add_i),
    .bank_wdata_i         (bank_wdata_i),
    .bank_rdata_o         (bank_rdata_o),
    .ecc_req_o            (ecc_req_o),
    .ecc_we_o             (ecc_we_o),
    .ecc_add_o            (ecc_add_o),
    .ecc_wdata_o          (ecc_wdata_o),
    .ecc_rdata_i          (ecc_rdata_i),
    .scrub_fix_o          (scrub_fix_o),
    .scrub_uncorrectable_o(scrub_uncorrectable_o),
    .nb_corrected_o       (nb_corrected_o),
    .nb_uncorrectable_o   (nb_uncorrectable_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model plus a backdoor preload port, all in one process
  logic [CwWidth-1:0] mem [BankSize];
  logic [CwWidth-1:0] rdata_q = '0;
  int unsigned        n_writes = 0;
  logic               pl_valid = 1'b0;
  logic [AW-1:0]      pl_addr = '0;
  logic [CwWidth-1:0] pl_data = '0;

  always @(posedge clk_i) begin
    if (pl_valid) mem[pl_addr] <= pl_data;
    if (ecc_req_o) begin
      if (ecc_we_o) begin
        mem[ecc_add_o] <= ecc_wdata_o;
        n_writes       <= n_writes + 1;
      end else begin
        rdata_q <= mem[ecc_add_o];
      end
    end
  end
  assign ecc_rdata_i = rdata_q;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input int unsigned a, input logic [CwWidth-1:0] d);
    pl_valid = 1'b1;
    pl_addr  = AW'(a);
    pl_data  = d;
    tick();
    pl_valid = 1'b0;
  endtask

  // Reference SECDED encoder: data on non-power-of-two positions, then check bits
  function automatic logic [CwWidth-1:0] enc(input logic [31:0] d);
    logic [CwWidth-1:0] cw;
    logic [5:0]         s;
    int unsigned        j;
    cw = '0;
    j  = 0;
    for (int unsigned p = 1; p < CwWidth; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    s = '0;
    for (int unsigned p = 1; p < CwWidth; p++) if (cw[p]) s = s ^ 6'(p);
    for (int unsigned k = 0; k < 6; k++) cw[1 << k] = s[k];
    cw[0] = ^cw[CwWidth-1:1];
    return cw;
  endfunction

  function automatic logic [31:0] pattern(input int unsigned a);
    return 32'h1234_5670 + 32'(a) * 32'h0101_0101;
  endfunction

  typedef struct {
    logic [CwWidth-1:0] flip;
    logic               fix;
    logic               unc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [CwWidth-1:0] one, good, bad, user_cw;
    int unsigned        exp_addr, exp_fix, exp_unc, w0;

    one = 1;
    vecs[0] = '{flip: '0,                        fix: 1'b0, unc: 1'b0};
    vecs[1] = '{flip: one << 0,                  fix: 1'b1, unc: 1'b0};
    vecs[2] = '{flip: one << 38,                 fix: 1'b1, unc: 1'b0};
    vecs[3] = '{flip: one << 5,                  fix: 1'b1, unc: 1'b0};
    vecs[4] = '{flip: (one << 2) | (one << 9),   fix: 1'b0, unc: 1'b1};
    vecs[5] = '{flip: one << 1,                  fix: 1'b1, unc: 1'b0};
    vecs[6] = '{flip: (one << 0) | (one << 1),   fix: 1'b0, unc: 1'b1};
    vecs[7] = '{flip: '0,                        fix: 1'b0, unc: 1'b0};

    rst_ni = 1'b0;
    scrub_trigger_i = 1'b0;
    bank_req_i = 1'b0;
    bank_we_i = 1'b0;
    bank_add_i = '0;
    bank_wdata_i = '0;
    for (int unsigned a = 0; a < BankSize; a++) preload(a, enc(pattern(a)));
    chk("rst_req", 64'(ecc_req_o), 64'(0));
    chk("rst_fix", 64'(scrub_fix_o), 64'(0));
    chk("rst_unc", 64'(scrub_uncorrectable_o), 64'(0));
    chk("rst_nbc", 64'(nb_corrected_o), 64'(0));
    chk("rst_nbu", 64'(nb_uncorrectable_o), 64'(0));
    rst_ni = 1'b1;
    tick();

    exp_addr = 0;
    exp_fix  = 0;
    exp_unc  = 0;
    for (int v = 0; v < 8; v++) begin
      good = enc(pattern(exp_addr));
      bad  = good ^ vecs[v].flip;
      preload(exp_addr, bad);
      w0 = n_writes;
      scrub_trigger_i = 1'b1;
      #1;
      chk($sformatf("rd_req[%0d]", v), 64'(ecc_req_o), 64'(1));
      chk($sformatf("rd_we[%0d]", v), 64'(ecc_we_o), 64'(0));
      chk($sformatf("rd_add[%0d]", v), 64'(ecc_add_o), 64'(exp_addr));
      tick();
      scrub_trigger_i = 1'b0;
      #1;
      chk($sformatf("read_idle_port[%0d]", v), 64'(ecc_req_o), 64'(0));
      tick();
      chk($sformatf("fix_pulse[%0d]", v), 64'(scrub_fix_o), 64'(vecs[v].fix));
      chk($sformatf("unc_pulse[%0d]", v), 64'(scrub_uncorrectable_o), 64'(vecs[v].unc));
      if (vecs[v].fix) begin
        chk($sformatf("wb_we[%0d]", v), 64'(ecc_req_o & ecc_we_o), 64'(1));
        chk($sformatf("wb_add[%0d]", v), 64'(ecc_add_o), 64'(exp_addr));
        chk($sformatf("wb_data[%0d]", v), 64'(ecc_wdata_o), 64'(good));
        exp_fix++;
      end
      if (vecs[v].unc) exp_unc++;
      chk($sformatf("nb_corr[%0d]", v), 64'(nb_corrected_o), 64'(exp_fix));
      chk($sformatf("nb_unc[%0d]", v), 64'(nb_uncorrectable_o), 64'(exp_unc));
      tick();
      chk($sformatf("mem[%0d]", v), 64'(mem[exp_addr]), 64'(vecs[v].unc ? bad : good));
      chk($sformatf("nwrites[%0d]", v), 64'(n_writes - w0), 64'(vecs[v].fix));
      exp_addr = (exp_addr + 1) % BankSize;
    end

    // Wrap: nine back-to-back steps on a clean bank
    for (int unsigned a = 0; a < BankSize; a++) preload(a, enc(pattern(a)));
    w0 = n_writes;
    for (int i = 0; i < 9; i++) begin
      scrub_trigger_i = 1'b1;
      #1;
      chk($sformatf("wrap_add[%0d]", i), 64'(ecc_add_o), 64'(i % BankSize));
      tick();
      scrub_trigger_i = 1'b0;
      tick();
    end
    chk("wrap_nwrites", 64'(n_writes - w0), 64'(0));

    // Trigger while the user owns the port is dropped
    bank_req_i = 1'b1;
    bank_add_i = 3'd6;
    scrub_trigger_i = 1'b1;
    #1;
    chk("drop_fwd_add", 64'(ecc_add_o), 64'(6));
    tick();
    bank_req_i = 1'b0;
    scrub_trigger_i = 1'b0;
    tick();
    scrub_trigger_i = 1'b1;
    #1;
    chk("drop_addr_kept", 64'(ecc_add_o), 64'(1));
    tick();
    scrub_trigger_i = 1'b0;
    tick();

    // Single error at 2, user write to 2 during WRITE discards the correction
    good    = enc(pattern(2));
    user_cw = enc(32'hDEAD_BEEF);
    preload(2, good ^ (one << 7));
    w0 = n_writes;
    exp_fix++;
    scrub_trigger_i = 1'b1;
    tick();
    scrub_trigger_i = 1'b0;
    bank_req_i = 1'b1;
    bank_we_i  = 1'b0;
    bank_add_i = 3'd5;
    #1;
    chk("read_fwd_req", 64'(ecc_req_o & ~ecc_we_o), 64'(1));
    chk("read_fwd_add", 64'(ecc_add_o), 64'(5));
    tick();
    bank_we_i    = 1'b1;
    bank_add_i   = 3'd2;
    bank_wdata_i = user_cw;
    #1;
    chk("hit_fix_pulse", 64'(scrub_fix_o), 64'(1));
    chk("hit_fwd_add", 64'(ecc_add_o), 64'(2));
    chk("hit_fwd_data", 64'(ecc_wdata_o), 64'(user_cw));
    tick();
    bank_req_i = 1'b0;
    bank_we_i  = 1'b0;
    #1;
    chk("hit_no_pending", 64'(ecc_req_o), 64'(0));
    tick();
    tick();
    chk("hit_mem", 64'(mem[2]), 64'(user_cw));
    chk("hit_nwrites", 64'(n_writes - w0), 64'(1));
    chk("hit_nb_corr", 64'(nb_corrected_o), 64'(exp_fix));
    scrub_trigger_i = 1'b1;
    #1;
    chk("hit_next_addr", 64'(ecc_add_o), 64'(3));
    tick();
    scrub_trigger_i = 1'b0;
    tick();

    // Reset while the write-back is on the port
    good = enc(pattern(4));
    preload(4, good ^ (one << 12));
    scrub_trigger_i = 1'b1;
    tick();
    scrub_trigger_i = 1'b0;
    tick();
    chk("rstw_we", 64'(ecc_req_o & ecc_we_o), 64'(1));
    w0 = n_writes;
    rst_ni = 1'b0;
    #1;
    chk("rstw_port_off", 64'(ecc_req_o), 64'(0));
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    tick();
    chk("rstw_nwrites", 64'(n_writes - w0), 64'(0));
    chk("rstw_mem", 64'(mem[4]), 64'(good ^ (one << 12)));
    chk("rstw_nbc", 64'(nb_corrected_o), 64'(0));
    chk("rstw_nbu", 64'(nb_uncorrectable_o), 64'(0));
    scrub_trigger_i = 1'b1;
    #1;
    chk("rstw_addr", 64'(ecc_add_o), 64'(0));
    tick();
    scrub_trigger_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
